fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC generation, single-outstanding imem fetch, 2-entry decode FIFO
// Option      : define IMM_PREDECODE_EN to register an immediate-format select per entry
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ValidD,
  input  logic        ReadyD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [2:0]  ImmSrcD
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] KILL = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_pc4   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        issue;
  logic        push;
  logic        pop;
  logic        unused_tgt_bits;

  // Only IDLE has nothing outstanding, so the FIFO count alone bounds the issue.
  assign issue    = !reset && (state == IDLE) && !PCSrcE && (count < 2'd2);
  assign push     = (state == WAIT) && ImemRValid && !PCSrcE;
  assign pop      = ValidD && ReadyD;
  assign ImemReq  = issue;
  assign ImemAddr = pc_f;
  assign ValidD   = (count != 2'd0);
  assign InstrD   = fifo_instr[rd_ptr];
  assign PCD      = fifo_pc[rd_ptr];
  assign PCPlus4D = fifo_pc4[rd_ptr];
  assign unused_tgt_bits = &{1'b0, PCTargetE[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc_f   <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      if (PCSrcE)
        pc_f <= {PCTargetE[31:2], 2'b00};
      else if (issue)
        pc_f <= pc_f + 32'd4;
      if (issue)
        req_pc <= pc_f;
      case (state)
        IDLE:    if (issue) state <= WAIT;
        WAIT: begin
          if (ImemRValid)  state <= IDLE;
          else if (PCSrcE) state <= KILL;
        end
        KILL:    if (ImemRValid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
      fifo_pc4[0]   <= 32'h0;
      fifo_pc4[1]   <= 32'h0;
    end else if (PCSrcE) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= ImemRData;
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_pc4[wr_ptr]   <= req_pc + 32'd4;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMM_PREDECODE_EN
  logic [2:0] fifo_imm [2];

  function automatic logic [2:0] predecode(input logic [6:0] opcode);
    case (opcode)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_imm[0] <= 3'b000;
      fifo_imm[1] <= 3'b000;
    end else if (push && !PCSrcE) begin
      fifo_imm[wr_ptr] <= predecode(ImemRData[6:0]);
    end
  end

  assign ImmSrcD = fifo_imm[rd_ptr];
`else
  assign ImmSrcD = 3'b000;
`endif

endmodule
`default_nettype wire
